// File: rtl/iq_lpf_decim.sv
// Integrate-and-dump low-pass/decimator for the demodulated I/Q baseband pair.
// Averages DECIM samples per channel, rounds half toward +inf, saturates, and strobes lpf_rdy.
module iq_lpf_decim #(
    parameter int IN_W  = 5,
    parameter int DECIM = 4,
    parameter int OUT_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    demod_rdy,
    input  logic signed [IN_W-1:0]  I_BB,
    input  logic signed [IN_W-1:0]  Q_BB,
    input  logic                    win_sync,
    output logic signed [OUT_W-1:0] I_LP,
    output logic signed [OUT_W-1:0] Q_LP,
    output logic                    lpf_rdy,
    output logic                    sat
);

    localparam int SHIFT = $clog2(DECIM);
    localparam int ACC_W = IN_W + SHIFT;
    localparam int CNT_W = SHIFT;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DUMP  = 1'b1;

    localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(DECIM - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(DECIM / 2);
    localparam logic signed [ACC_W-1:0] OUT_MAX    = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN    = ACC_W'(-(2 ** (OUT_W - 1)));

    // The bias cannot overflow ACC_W: the largest window sum is 2^(ACC_W-1) - DECIM.
    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] biased;
        biased = sum + ROUND_HALF;
        return biased >>> SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > OUT_MAX) begin
            return {1'b1, OUT_MAX[OUT_W-1:0]};
        end else if (v < OUT_MIN) begin
            return {1'b1, OUT_MIN[OUT_W-1:0]};
        end
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0] sum_i_q, sum_i_d;
    logic signed [ACC_W-1:0] sum_q_q, sum_q_d;
    logic signed [OUT_W-1:0] i_lp_q, i_lp_d;
    logic signed [OUT_W-1:0] q_lp_q, q_lp_d;
    logic                    lpf_rdy_q, lpf_rdy_d;
    logic                    sat_q, sat_d;

    logic signed [ACC_W-1:0] samp_i, samp_q;
    logic signed [ACC_W-1:0] base_acc_i, base_acc_q;
    logic [CNT_W-1:0]        base_cnt;
    logic [OUT_W:0]          res_i, res_q;

    assign samp_i = {{SHIFT{I_BB[IN_W-1]}}, I_BB};
    assign samp_q = {{SHIFT{Q_BB[IN_W-1]}}, Q_BB};
    assign res_i  = saturate(round_shift(sum_i_q));
    assign res_q  = saturate(round_shift(sum_q_q));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_i_d   = acc_i_q;
        acc_q_d   = acc_q_q;
        sum_i_d   = sum_i_q;
        sum_q_d   = sum_q_q;
        i_lp_d    = i_lp_q;
        q_lp_d    = q_lp_q;
        lpf_rdy_d = 1'b0;
        sat_d     = sat_q;

        if (state_q == ST_DUMP) begin
            i_lp_d    = res_i[OUT_W-1:0];
            q_lp_d    = res_q[OUT_W-1:0];
            lpf_rdy_d = 1'b1;
            sat_d     = sat_q | res_i[OUT_W] | res_q[OUT_W];
            state_d   = ST_ACCUM;
        end

        // Accumulation runs in both states so a strobe during DUMP opens the next window.
        base_acc_i = win_sync ? '0 : acc_i_q;
        base_acc_q = win_sync ? '0 : acc_q_q;
        base_cnt   = win_sync ? '0 : cnt_q;
        acc_i_d    = base_acc_i;
        acc_q_d    = base_acc_q;
        cnt_d      = base_cnt;

        if (demod_rdy) begin
            if (base_cnt == CNT_LAST) begin
                sum_i_d = base_acc_i + samp_i;
                sum_q_d = base_acc_q + samp_q;
                acc_i_d = '0;
                acc_q_d = '0;
                cnt_d   = '0;
                state_d = ST_DUMP;
            end else begin
                acc_i_d = base_acc_i + samp_i;
                acc_q_d = base_acc_q + samp_q;
                cnt_d   = base_cnt + CNT_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ACCUM;
            cnt_q     <= '0;
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            sum_i_q   <= '0;
            sum_q_q   <= '0;
            i_lp_q    <= '0;
            q_lp_q    <= '0;
            lpf_rdy_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            sum_i_q   <= sum_i_d;
            sum_q_q   <= sum_q_d;
            i_lp_q    <= i_lp_d;
            q_lp_q    <= q_lp_d;
            lpf_rdy_q <= lpf_rdy_d;
            sat_q     <= sat_d;
        end
    end

    assign I_LP    = i_lp_q;
    assign Q_LP    = q_lp_q;
    assign lpf_rdy = lpf_rdy_q;
    assign sat     = sat_q;

endmodule
